// File: rtl/level_meter.sv
// level_meter: peak-hold audio level envelope for an LED bar display.
// Stage 1 registers |sample| (with -2^23 saturated to 0x7FFFFF); stage 2
// runs the IDLE/HOLD/DECAY envelope FSM and updates level.
// Optional clip indicator timer is built only when LEVEL_METER_CLIP_EN is defined.
module level_meter #(
  parameter int unsigned HOLD_SAMPLES = 4800,
  parameter int unsigned DECAY_SHIFT  = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        sample_valid,
  input  logic [23:0] sample,
  output logic [23:0] level,
  output logic        level_valid,
  output logic        clip
);

  localparam logic [23:0] FULL_SCALE  = 24'h7FFFFF;
  localparam logic [23:0] NEG_FULL    = 24'h800000;
  localparam logic [15:0] HOLD_RELOAD = 16'(HOLD_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] hold_cnt, hold_cnt_nxt;
  logic [23:0] level_nxt;

  logic        s1_valid;
  logic [23:0] s1_mag;
  logic [23:0] mag_in;

  logic [23:0] decay_step;
  logic [23:0] decay_val;

  // Absolute value of the incoming sample, saturating the one unrepresentable case
  always_comb begin
    mag_in = sample;
    if (sample == NEG_FULL) begin
      mag_in = FULL_SCALE;
    end else if (sample[23]) begin
      mag_in = ~sample + 24'd1;
    end
  end

  // Stage 1: magnitude register and its valid flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_mag   <= '0;
    end else begin
      s1_valid <= sample_valid;
      if (sample_valid) begin
        s1_mag <= mag_in;
      end
    end
  end

  // Decay candidate: level minus max(level >> DECAY_SHIFT, 1), floored at the new sample
  always_comb begin
    decay_step = level >> DECAY_SHIFT;
    if (decay_step == '0) begin
      decay_step = 24'd1;
    end
    // level is nonzero whenever this result is used, so the subtraction never wraps
    decay_val = level - decay_step;
    if (s1_mag > decay_val) begin
      decay_val = s1_mag;
    end
  end

  // Envelope FSM next state; only advances on cycles carrying a stage-1 result
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    level_nxt    = level;
    if (s1_valid) begin
      if ((s1_mag >= level) && (s1_mag != '0)) begin
        level_nxt    = s1_mag;
        hold_cnt_nxt = HOLD_RELOAD;
        state_nxt    = HOLD;
      end else begin
        unique case (state)
          IDLE: begin
            level_nxt = '0;
          end
          HOLD: begin
            if (hold_cnt == '0) begin
              state_nxt = DECAY;
            end else begin
              hold_cnt_nxt = hold_cnt - 16'd1;
            end
            if (level == '0) begin
              state_nxt = IDLE;
            end
          end
          DECAY: begin
            level_nxt = decay_val;
            if (decay_val == '0) begin
              state_nxt = IDLE;
            end
          end
          default: begin
            state_nxt = IDLE;
            level_nxt = '0;
          end
        endcase
      end
    end
  end

  // Stage 2: envelope state, level and the re-evaluation pulse
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      level       <= '0;
      level_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_cnt_nxt;
      level       <= level_nxt;
      level_valid <= s1_valid;
    end
  end

`ifdef LEVEL_METER_CLIP_EN
  logic [15:0] clip_cnt;

  // Clip indicator: set on a full-scale magnitude, cleared HOLD_SAMPLES valid samples later
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clip     <= 1'b0;
      clip_cnt <= '0;
    end else if (s1_valid) begin
      if (s1_mag == FULL_SCALE) begin
        clip     <= 1'b1;
        clip_cnt <= 16'(HOLD_SAMPLES);
      end else if (clip_cnt != '0) begin
        clip_cnt <= clip_cnt - 16'd1;
        if (clip_cnt == 16'd1) begin
          clip <= 1'b0;
        end
      end
    end
  end
`else
  assign clip = 1'b0;
`endif

endmodule

// File: doc/level_meter.md
LEVEL_METER -- requirements
Module: level_meter

Interface
REQ-001 The block SHALL have parameter HOLD_SAMPLES, default 4800, giving the peak-hold duration in valid samples (range 1..65535).
REQ-002 The block SHALL have parameter DECAY_SHIFT, default 4, giving the decay step as level >> DECAY_SHIFT per valid sample (range 1..23).
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port sample_valid, input, 1 bit: qualifies sample for one clock; may be high on consecutive cycles.
REQ-006 Port sample, input, 24 bits: signed two's-complement audio sample.
REQ-007 Port level, output, 24 bits: unsigned peak-hold envelope magnitude, directly drivable into the LED bar display.
REQ-008 Port level_valid, output, 1 bit: one-cycle pulse each time level is re-evaluated.
REQ-009 Port clip, output, 1 bit: clip indicator; present in all builds.

Function
REQ-010 Stage 1 SHALL register mag = |sample| when sample_valid=1; sample = -2^23 (0x800000) SHALL saturate to 0x7FFFFF.
REQ-011 Stage 2 SHALL update level and FSM one cycle after stage 1; latency sample_valid -> level_valid is exactly 2 cycles.
REQ-012 No state, counter or level change SHALL occur on cycles with no stage-1 result.
REQ-013 The FSM SHALL have states IDLE (level=0), HOLD, DECAY.
REQ-014 Any state, mag >= level and mag != 0: level <= mag, hold counter <= HOLD_SAMPLES-1, state <= HOLD; mag == level counts as a new peak and restarts hold.
REQ-015 HOLD, mag < level: counter decrements by 1; on a sample with counter == 0, state <= DECAY and level stays unchanged.
REQ-016 DECAY, mag < level: level <= max(mag, level - max(level >> DECAY_SHIFT, 1)).
REQ-017 DECAY or HOLD: when the new level equals 0, state <= IDLE.
REQ-018 IDLE, mag == 0: level stays 0 and state stays IDLE; level_valid still pulses.
REQ-019 Back-to-back valid samples on every clock SHALL be processed without loss.
REQ-020 Level arithmetic SHALL be 24-bit unsigned and never wrap below 0 or above 0x7FFFFF.

Reset
REQ-021 resetn=0 SHALL asynchronously force level=0, level_valid=0, clip=0, state IDLE, hold counter 0, and clear the stage-1 register and its valid flag.
REQ-022 A sample in flight when reset asserts SHALL be discarded, and no level_valid SHALL occur for it after release.
REQ-023 The first sample accepted after reset release SHALL follow normal 2-cycle latency.

Configuration
REQ-024 Macro LEVEL_METER_CLIP_EN defined: clip SHALL set in stage 2 when mag == 0x7FFFFF, and stay set for HOLD_SAMPLES further valid samples after the last clipping sample, then clear.
REQ-025 Macro LEVEL_METER_CLIP_EN defined: a new clipping sample SHALL restart the clip timer.
REQ-026 Macro LEVEL_METER_CLIP_EN undefined: clip SHALL be constant 0 and the clip timer logic SHALL NOT be built.

Verification
REQ-027 Reset, then valid sample 0x000100: level=0x000100 and level_valid pulse exactly 2 cycles after the valid, state HOLD.
REQ-028 Valid sample 0xFFFF00 (-256) after level 0x000080: level=0x000100, with negative magnitude handled.
REQ-029 HOLD_SAMPLES=4, DECAY_SHIFT=4, peak 0x001000, then zero samples: level holds for 4 samples, then follows 0x000F00, 0x000E10, ... down to 0 (min step 1); state IDLE at 0.
REQ-030 Sample 0x800000 with LEVEL_METER_CLIP_EN defined: level=0x7FFFFF and clip=1; clip clears after HOLD_SAMPLES more valid samples; without the macro, clip stays 0.
REQ-031 sample_valid held high for 16 cycles with a ramp of samples: 16 level_valid pulses, and level tracks the running peak.
REQ-032 resetn pulsed low one cycle after a valid 0x7FFFFF: level=0, clip=0, and no level_valid after release.
